capture_sequencer: RTL and testbench

//  Sequences one acquisition: stores sampler output in a circular sample RAM while armed, counts post-trigger

---
 rtl/capture_seq_pkg.sv | 27 ++
 rtl/capture_ram.sv | 28 ++
 rtl/capture_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_seq_pkg.sv
// Shared types and helpers for the capture sequencer: FSM state encoding,
// bytes-per-sample calculation and little-endian byte selection.
package capture_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    READ,
    SEND,
    WAIT_TX,
    DONE
  } state_e;

  // Widest sample the byte selector can slice; SAMPLE_WIDTH must not exceed it.
  localparam int unsigned MAX_SAMPLE_WIDTH = 64;

  function automatic int unsigned bps(input int unsigned width);
    return (width + 7) / 8;
  endfunction

  function automatic logic [7:0] sel_byte(input logic [MAX_SAMPLE_WIDTH-1:0] word,
                                          input logic [2:0]                  idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// Written so synthesis maps it onto block RAM.
module capture_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: neither the array nor the read register has a reset; a reset would
  // stop the memory from mapping onto a block RAM primitive.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/capture_sequencer.sv
// Captures samples into a circular RAM, counts post-trigger samples, then streams the
// stored samples newest-first as bytes to the UART. Define TEST_PATTERN_EN for a counting test source.
module capture_sequencer
  import capture_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    load_counts,
  input  logic [COUNT_WIDTH-1:0]  read_count,
  input  logic [COUNT_WIDTH-1:0]  delay_count,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  input  logic                    run,
  input  logic                    tx_busy,
`ifdef TEST_PATTERN_EN
  input  logic                    test_mode,
`endif
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned BPS    = bps(SAMPLE_WIDTH);
  localparam int unsigned FILL_W = DEPTH_LOG2 + 1;
  localparam int unsigned N_W    = COUNT_WIDTH + 1;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [FILL_W-1:0]       k_q, k_d;
  logic [COUNT_WIDTH-1:0]  read_cnt_q, read_cnt_d;
  logic [COUNT_WIDTH-1:0]  delay_cnt_q, delay_cnt_d;
  logic [COUNT_WIDTH-1:0]  dly_q, dly_d;
  logic [N_W-1:0]          n_q, n_d;
  logic [2:0]              byte_idx_q, byte_idx_d;
  logic                    seen_busy_q, seen_busy_d;
  logic [7:0]              tx_data_q, tx_data_d;

  logic                    wr_en;
  logic                    rd_en;
  logic                    start_read;
  logic [SAMPLE_WIDTH-1:0] wr_data;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic [N_W-1:0]          n_req;
  logic [N_W-1:0]          n_init;
  logic [7:0]              send_byte;

  // Only ARMED and POST store samples; anything arriving later is dropped.
  assign wr_en = sample_valid && (state_q == ARMED || state_q == POST);

`ifdef TEST_PATTERN_EN
  logic [SAMPLE_WIDTH-1:0] pat_q, pat_d;

  assign wr_data = test_mode ? pat_q : sample_data;

  always_comb begin
    pat_d = pat_q;
    if (state_q == IDLE && arm) pat_d = '0;
    else if (wr_en)             pat_d = pat_q + SAMPLE_WIDTH'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pat_q <= '0;
    else       pat_q <= pat_d;
  end
`else
  assign wr_data = sample_data;
`endif

  capture_ram #(
    .DATA_WIDTH (SAMPLE_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Never return more samples than the RAM can hold.
  assign n_req  = {1'b0, read_cnt_q} + N_W'(1);
  assign n_init = (n_req > N_W'(DEPTH)) ? N_W'(DEPTH) : n_req;

  assign send_byte = (k_q >= fill_q) ? 8'h00
                   : sel_byte(MAX_SAMPLE_WIDTH'(rd_data), byte_idx_q);

  // NOTE: every signal driven here gets its default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    k_d         = k_q;
    read_cnt_d  = read_cnt_q;
    delay_cnt_d = delay_cnt_q;
    dly_d       = dly_q;
    n_d         = n_q;
    byte_idx_d  = byte_idx_q;
    seen_busy_d = seen_busy_q;
    tx_data_d   = tx_data_q;
    rd_en       = 1'b0;
    tx_start    = 1'b0;
    start_read  = 1'b0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (load_counts) begin
          read_cnt_d  = read_count;
          delay_cnt_d = delay_count;
        end
        if (arm) begin
          state_d  = ARMED;
          wr_ptr_d = '0;
          fill_d   = '0;
        end
      end
      ARMED: begin
        if (run) begin
          dly_d = delay_cnt_q;
          if (delay_cnt_q == '0) start_read = 1'b1;
          else                   state_d    = POST;
        end
      end
      POST: begin
        if (dly_q == '0) begin
          start_read = 1'b1;
        end else if (sample_valid) begin
          dly_d = dly_q - COUNT_WIDTH'(1);
          if (dly_q == COUNT_WIDTH'(1)) start_read = 1'b1;
        end
      end
      READ: begin
        rd_en   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        tx_start    = 1'b1;
        tx_data_d   = send_byte;
        seen_busy_d = 1'b0;
        state_d     = WAIT_TX;
      end
      WAIT_TX: begin
        // A byte is finished only after busy has been seen high and then low.
        if (!seen_busy_q) begin
          if (tx_busy) seen_busy_d = 1'b1;
        end else if (!tx_busy) begin
          if (byte_idx_q == 3'(BPS - 1)) begin
            byte_idx_d = '0;
            rd_ptr_d   = rd_ptr_q - DEPTH_LOG2'(1);
            n_d        = n_q - N_W'(1);
            k_d        = k_q + FILL_W'(1);
            state_d    = (n_q == N_W'(1)) ? DONE : READ;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = SEND;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The newest sample sits just behind the write pointer, including one written this cycle.
    if (start_read) begin
      state_d    = READ;
      n_d        = n_init;
      rd_ptr_d   = wr_ptr_d - DEPTH_LOG2'(1);
      k_d        = '0;
      byte_idx_d = '0;
    end

    if (abort) begin
      state_d  = IDLE;
      tx_start = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      k_q         <= '0;
      read_cnt_q  <= '0;
      delay_cnt_q <= '0;
      dly_q       <= '0;
      n_q         <= '0;
      byte_idx_q  <= '0;
      seen_busy_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      k_q         <= k_d;
      read_cnt_q  <= read_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      dly_q       <= dly_d;
      n_q         <= n_d;
      byte_idx_q  <= byte_idx_d;
      seen_busy_q <= seen_busy_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // tx_data follows the RAM in SEND and is then held until the next byte.
  assign tx_data = (state_q == SEND) ? send_byte : tx_data_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: 8-bit and 12-bit instances, a UART responder,
// and a queue-based model of what must come out newest-first.
module tb_capture_sequencer;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        arm, abort, load_counts, sample_valid, run, tx_busy, test_mode, sel;
  logic [15:0] read_count, delay_count;
  logic [11:0] sample_data;
  logic        arm8, arm12, lc8, lc12;
  logic [7:0]  tx_data8, tx_data12, tx_data_m;
  logic        tx_start8, tx_start12, tx_start_m;
  logic        busy8, busy12, busy_m, done8, done12, done_m;

  assign arm8       = arm & ~sel;
  assign arm12      = arm & sel;
  assign lc8        = load_counts & ~sel;
  assign lc12       = load_counts & sel;
  assign tx_data_m  = sel ? tx_data12  : tx_data8;
  assign tx_start_m = sel ? tx_start12 : tx_start8;
  assign busy_m     = sel ? busy12     : busy8;
  assign done_m     = sel ? done12     : done8;

  capture_sequencer #(.SAMPLE_WIDTH(8), .DEPTH_LOG2(4), .COUNT_WIDTH(16)) dut8 (
    .clock        (clock),
    .reset        (reset),
    .arm          (arm8),
    .abort        (abort),
    .load_counts  (lc8),
    .read_count   (read_count),
    .delay_count  (delay_count),
    .sample_data  (sample_data[7:0]),
    .sample_valid (sample_valid),
    .run          (run),
    .tx_busy      (tx_busy),
`ifdef TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .tx_data      (tx_data8),
    .tx_start     (tx_start8),
    .busy         (busy8),
    .done         (done8)
  );

  capture_sequencer #(.SAMPLE_WIDTH(12), .DEPTH_LOG2(4), .COUNT_WIDTH(16)) dut12 (
    .clock        (clock),
    .reset        (reset),
    .arm          (arm12),
    .abort        (abort),
    .load_counts  (lc12),
    .read_count   (read_count),
    .delay_count  (delay_count),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .run          (run),
    .tx_busy      (tx_busy),
`ifdef TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .tx_data      (tx_data12),
    .tx_start     (tx_start12),
    .busy         (busy12),
    .done         (done12)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  got_q[$];
  int          start_cnt = 0;
  int          done_cnt  = 0;
  int          uart_cnt  = 0;
  logic [7:0]  hold_byte = 8'h00;
  bit          prev_done = 1'b0;

  logic [11:0] pre_q[$];
  logic [11:0] post_q[$];
  logic [11:0] written[$];
  logic [11:0] trig_val;
  bit          trig_valid;
  logic [11:0] pat;
  int          lat_rd  = 0;
  int          lat_dly = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART responder: goes busy for a random time after each tx_start.
  always @(negedge clock) begin
    if (!reset) begin
      if (uart_cnt > 0) begin
        check("start_busy", 32'(tx_start_m), 32'd0);
        check("tx_hold", 32'(tx_data_m), 32'(hold_byte));
        uart_cnt--;
        if (uart_cnt == 0) tx_busy = 1'b0;
      end else if (tx_start_m) begin
        got_q.push_back(tx_data_m);
        start_cnt++;
        hold_byte = tx_data_m;
        tx_busy   = 1'b1;
        uart_cnt  = 2 + int'($urandom_range(0, 3));
      end
      if (done_m) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
      end
      prev_done = done_m;
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) cycle();
  endtask

  task automatic record(input logic [11:0] v, input logic [11:0] mask);
    written.push_back(test_mode ? pat : (v & mask));
    pat = (pat + 12'd1) & mask;
  endtask

  task automatic fill_random(input int npre, input int npost);
    pre_q.delete();
    post_q.delete();
    for (int i = 0; i < npre; i++)  pre_q.push_back(12'($urandom));
    for (int i = 0; i < npost; i++) post_q.push_back(12'($urandom));
    trig_val   = 12'($urandom);
    trig_valid = 1'($urandom);
  endtask

  // One full acquisition; abort_at >= 0 aborts while waiting on that many-th byte's busy.
  task automatic capture(input bit wide, input bit do_load, input int rd, input int dly,
                         input int abort_at);
    logic [11:0] mask;
    logic [7:0]  exp_q[$];
    logic [11:0] s;
    int          done_base, L, n, bpsm, waited, ncmp;
    bit          aborted;
    mask      = wide ? 12'hFFF : 12'h0FF;
    sel       = wide;
    got_q.delete();
    written.delete();
    pat       = '0;
    done_base = done_cnt;
    aborted   = 1'b0;

    if (do_load) begin
      read_count  = 16'(rd);
      delay_count = 16'(dly);
      load_counts = 1'b1;
      cycle();
      load_counts = 1'b0;
      lat_rd      = rd;
      lat_dly     = dly;
    end
    arm = 1'b1;
    cycle();
    check("busy_armed", 32'(busy_m), 32'd1);
    // arm and load_counts while busy must both be ignored.
    load_counts = 1'b1;
    read_count  = 16'h0000;
    delay_count = 16'h0007;
    cycle();
    arm         = 1'b0;
    load_counts = 1'b0;

    foreach (pre_q[i]) begin
      idle_gap();
      sample_valid = 1'b1;
      sample_data  = pre_q[i];
      record(pre_q[i], mask);
      if ($urandom_range(0, 7) == 0) arm = 1'b1;
      cycle();
      sample_valid = 1'b0;
      arm          = 1'b0;
    end
    run          = 1'b1;
    sample_valid = trig_valid;
    sample_data  = trig_val;
    if (trig_valid) record(trig_val, mask);
    cycle();
    sample_valid = 1'b0;
    foreach (post_q[i]) begin
      idle_gap();
      sample_valid = 1'b1;
      sample_data  = post_q[i];
      if (i < lat_dly) record(post_q[i], mask);
      cycle();
      sample_valid = 1'b0;
    end
    run = 1'b0;

    waited = 0;
    while (done_cnt == done_base && waited < 3000) begin
      if (abort_at >= 0 && got_q.size() == abort_at && tx_busy) begin
        abort = 1'b1;
        cycle();
        abort   = 1'b0;
        aborted = 1'b1;
        break;
      end
      cycle();
      waited++;
    end

    L    = written.size();
    n    = (lat_rd + 1 > DEPTH) ? DEPTH : lat_rd + 1;
    bpsm = wide ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      s = (i < L) ? written[L - 1 - i] : 12'h000;
      for (int b = 0; b < bpsm; b++) exp_q.push_back(8'((s >> (8 * b)) & 12'h0FF));
    end

    if (abort_at >= 0) begin
      check("abort_seen", 32'(aborted), 32'd1);
      check("abort_idle", 32'(busy_m), 32'd0);
      repeat (60) cycle();
      check("abort_nostart", 32'(got_q.size()), 32'(abort_at));
      check("abort_nodone", 32'(done_cnt - done_base), 32'd0);
      ncmp = abort_at;
    end else begin
      check("done_timeout", 32'(waited < 3000), 32'd1);
      cycle();
      check("busy_after_done", 32'(busy_m), 32'd0);
      check("done_count", 32'(done_cnt - done_base), 32'd1);
      check("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
      ncmp = exp_q.size();
    end
    for (int i = 0; i < ncmp; i++) begin
      if (i < got_q.size()) check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    reset        = 1'b1;
    arm          = 1'b0;
    abort        = 1'b0;
    load_counts  = 1'b0;
    sample_valid = 1'b0;
    run          = 1'b0;
    tx_busy      = 1'b0;
    test_mode    = 1'b0;
    sel          = 1'b0;
    read_count   = '0;
    delay_count  = '0;
    sample_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_busy12", 32'(busy12), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_start8", 32'(tx_start8), 32'd0);
    check("rst_data8", 32'(tx_data8), 32'd0);
    check("rst_data12", 32'(tx_data12), 32'd0);
    reset = 1'b0;
    cycle();

    // Trigger sample plus two delayed samples, last four returned.
    pre_q = '{12'h10, 12'h11, 12'h12};
    trig_valid = 1'b1;
    trig_val   = 12'h13;
    post_q = '{12'h14, 12'h15, 12'h16, 12'h17};
    capture(1'b0, 1'b1, 3, 2, -1);

    // Pointer wrap: 20 samples into a 16-deep RAM.
    pre_q.delete();
    for (int i = 0; i < 20; i++) pre_q.push_back(12'(i));
    trig_valid = 1'b0;
    post_q = '{12'h01, 12'h02};
    capture(1'b0, 1'b1, 15, 0, -1);

    // Fewer samples stored than requested: zero padding.
    pre_q = '{12'h0A1, 12'h0A2};
    trig_valid = 1'b0;
    post_q.delete();
    capture(1'b0, 1'b1, 3, 0, -1);

    // 12-bit sample sent as two bytes, LSB first.
    pre_q = '{12'hABC};
    trig_valid = 1'b0;
    post_q.delete();
    capture(1'b1, 1'b1, 0, 0, -1);

    // Abort while the second byte is in flight.
    pre_q = '{12'h30, 12'h31, 12'h32, 12'h33, 12'h34, 12'h35};
    trig_valid = 1'b1;
    trig_val   = 12'h36;
    post_q = '{12'h37, 12'h38};
    capture(1'b0, 1'b1, 3, 1, 2);

    // arm together with abort in IDLE stays in IDLE.
    sel   = 1'b0;
    arm   = 1'b1;
    abort = 1'b1;
    cycle();
    arm   = 1'b0;
    abort = 1'b0;
    check("arm_abort_idle", 32'(busy8), 32'd0);

    // Counts latched before the abort must still be in force.
    fill_random(5, 3);
    capture(1'b0, 1'b0, 3, 1, -1);

    for (int t = 0; t < 10; t++) begin
      int dly;
      dly = int'($urandom_range(0, 5));
      fill_random(int'($urandom_range(0, 24)), dly + int'($urandom_range(0, 3)));
      capture(1'($urandom_range(0, 2) == 0), 1'b1, int'($urandom_range(0, 20)), dly, -1);
    end

`ifdef TEST_PATTERN_EN
    test_mode = 1'b1;
    fill_random(4, 0);
    trig_valid = 1'b0;
    capture(1'b0, 1'b1, 3, 0, -1);
    test_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
